player_ctrl: RTL and testbench

- Per-player motion and animation sequencer for the 32x32 player sprite renderers.
- Once per video frame, it reads direction buttons and asks the maze block whether the candidate position is free, using a req/ack handshake.
- It then updates the sprite's top-left position and selects the sprite number. It also runs the death/respawn sequence.
- One instance per player; its position and sprite outputs drive the renderer's centerX/centerY and sprite_num inputs directly.

---
 rtl/player_ctrl_pkg.sv | 22 ++
 rtl/player_ctrl_if.sv | 12 +
 rtl/player_ctrl_frame_counter.sv | 24 ++
 rtl/player_ctrl.sv | 167 ++++++++++++++++
 tb/tb_player_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player sprite sequencer: sprite indices,
// controller states and sprite geometry.
package bomber_pkg;

    localparam int SPRITE_SIZE = 32;

    localparam logic [2:0] SPR_IDLE  = 3'd0;
    localparam logic [2:0] SPR_UP    = 3'd1;
    localparam logic [2:0] SPR_DOWN  = 3'd2;
    localparam logic [2:0] SPR_LEFT  = 3'd3;
    localparam logic [2:0] SPR_RIGHT = 3'd4;
    localparam logic [2:0] SPR_DEAD0 = 3'd5;
    localparam logic [2:0] SPR_DEAD1 = 3'd6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        CHECK  = 2'd2,
        DEAD   = 2'd3
    } state_t;

endpackage

// File: rtl/player_ctrl_if.sv
// Maze occupancy check handshake: the controller proposes a candidate
// top-left position and the maze answers with an ack strobe and a free flag.
interface player_ctrl_if;
    logic       check_req;
    logic [9:0] check_x;
    logic [9:0] check_y;
    logic       check_ack;
    logic       check_free;

    modport master (output check_req, check_x, check_y, input check_ack, check_free);
    modport slave  (input check_req, check_x, check_y, output check_ack, check_free);
endinterface

// File: rtl/player_ctrl_frame_counter.sv
// Frame-tick counter with synchronous clear; tc flags the last count of the
// period so the owner can act on the tick that completes it (count then wraps).
module frame_counter #(
    parameter int TC = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic tc
);
    localparam int W = $clog2(TC + 1);

    logic [W-1:0] count;

    assign tc = (count == W'(TC - 1));

    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (tick)
            count <= tc ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/player_ctrl.sv
// Per-player motion/animation sequencer: one maze-checked move per frame,
// plus the death animation and respawn timer.
//
// state  | meaning
// IDLE   | waiting for frame_tick (or hit)
// DECIDE | pick direction, bound-check candidate, maybe request maze check
// CHECK  | holding check_req until the maze acks
// DEAD   | death animation; respawn after DEATH_FRAMES frames
module player_ctrl
    import bomber_pkg::*;
#(
    parameter int STEP         = 2,
    parameter int X_MIN        = 32,
    parameter int X_MAX        = 576,
    parameter int Y_MIN        = 32,
    parameter int Y_MAX        = 416,
    parameter int START_X      = 32,
    parameter int START_Y      = 32,
    parameter int ANIM_DIV     = 8,
    parameter int DEATH_FRAMES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               hit,
    player_ctrl_if.master      chk,
    output logic [9:0]         player_centerX,
    output logic [9:0]         player_centerY,
    output logic [2:0]         sprite_num,
    output logic               alive
);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    state_t            state;
    logic              req_q;
    logic [9:0]        cx_q, cy_q;
    logic [2:0]        move_spr;
    logic              pending_hit;
    logic              death_tc, anim_tc;

    logic signed [10:0] cand_x, cand_y;
    logic [2:0]         dir_spr;
    logic               any_btn, cand_ok;

    assign chk.check_req = req_q;
    assign chk.check_x   = cx_q;
    assign chk.check_y   = cy_q;

    // Timers only run inside DEAD so every death starts from zero.
    frame_counter #(.TC(DEATH_FRAMES)) u_death (
        .clk(clk), .reset(reset), .clear(state != DEAD), .tick(frame_tick), .tc(death_tc)
    );
    frame_counter #(.TC(ANIM_DIV)) u_anim (
        .clk(clk), .reset(reset), .clear(state != DEAD), .tick(frame_tick), .tc(anim_tc)
    );

    always_comb begin
        cand_x  = $signed({1'b0, player_centerX});
        cand_y  = $signed({1'b0, player_centerY});
        dir_spr = SPR_IDLE;
        any_btn = 1'b1;
        if (btn_up) begin
            cand_y  = cand_y - STEP_S;
            dir_spr = SPR_UP;
        end else if (btn_down) begin
            cand_y  = cand_y + STEP_S;
            dir_spr = SPR_DOWN;
        end else if (btn_left) begin
            cand_x  = cand_x - STEP_S;
            dir_spr = SPR_LEFT;
        end else if (btn_right) begin
            cand_x  = cand_x + STEP_S;
            dir_spr = SPR_RIGHT;
        end else begin
            any_btn = 1'b0;
        end
        cand_ok = (cand_x >= X_MIN_S) && (cand_x <= X_MAX_S) &&
                  (cand_y >= Y_MIN_S) && (cand_y <= Y_MAX_S);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            player_centerX <= 10'(START_X);
            player_centerY <= 10'(START_Y);
            sprite_num     <= SPR_IDLE;
            alive          <= 1'b1;
            req_q          <= 1'b0;
            cx_q           <= '0;
            cy_q           <= '0;
            move_spr       <= SPR_IDLE;
            pending_hit    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state      <= DEAD;
                        alive      <= 1'b0;
                        sprite_num <= SPR_DEAD0;
                    end else if (frame_tick) begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (hit) begin
                        state      <= DEAD;
                        alive      <= 1'b0;
                        sprite_num <= SPR_DEAD0;
                    end else if (!any_btn || !cand_ok) begin
                        sprite_num <= dir_spr;
                        state      <= IDLE;
                    end else begin
                        cx_q        <= cand_x[9:0];
                        cy_q        <= cand_y[9:0];
                        req_q       <= 1'b1;
                        move_spr    <= dir_spr;
                        pending_hit <= 1'b0;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (hit)
                        pending_hit <= 1'b1;
                    // A hit during the handshake lets it finish but voids the move.
                    if (chk.check_ack) begin
                        req_q <= 1'b0;
                        if (pending_hit || hit) begin
                            state       <= DEAD;
                            alive       <= 1'b0;
                            sprite_num  <= SPR_DEAD0;
                            pending_hit <= 1'b0;
                        end else begin
                            if (chk.check_free) begin
                                player_centerX <= cx_q;
                                player_centerY <= cy_q;
                            end
                            sprite_num <= move_spr;
                            state      <= IDLE;
                        end
                    end
                end
                DEAD: begin
                    if (frame_tick) begin
                        if (death_tc) begin
                            player_centerX <= 10'(START_X);
                            player_centerY <= 10'(START_Y);
                            sprite_num     <= SPR_IDLE;
                            alive          <= 1'b1;
                            state          <= IDLE;
                        end else if (anim_tc) begin
                            sprite_num <= (sprite_num == SPR_DEAD0) ? SPR_DEAD1 : SPR_DEAD0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: vector table of single frames with a behavioural
// maze responder, scoreboard of expected positions, and death/reset sequences.
module tb_player_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       hit = 1'b0;
    logic [9:0] px, py;
    logic [2:0] spr;
    logic       alive;

    player_ctrl_if chk_if ();

    player_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .hit(hit), .chk(chk_if),
        .player_centerX(px), .player_centerY(py), .sprite_num(spr), .alive(alive)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { int x; int y; int spr; int alv; } obs_t;
    obs_t sb[$];

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        int delay;
        bit free;
        bit exp_req;
        int cx, cy;
        int x, y, spr;
    } vec_t;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int x, input int y, input int s, input int a);
        obs_t e;
        e.x = x; e.y = y; e.spr = s; e.alv = a;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        obs_t e;
        cmp({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        cmp({tag, "_x"}, 32'(px), 32'(e.x));
        cmp({tag, "_y"}, 32'(py), 32'(e.y));
        cmp({tag, "_spr"}, 32'(spr), 32'(e.spr));
        cmp({tag, "_alive"}, 32'(alive), 32'(e.alv));
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = v.btn;
        frame_tick = 1'b1;
        push_exp(v.x, v.y, v.spr, 1);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        cmp({tag, "_req"}, 32'(chk_if.check_req), 32'(v.exp_req));
        if (v.exp_req && chk_if.check_req) begin
            cmp({tag, "_cx"}, 32'(chk_if.check_x), 32'(v.cx));
            cmp({tag, "_cy"}, 32'(chk_if.check_y), 32'(v.cy));
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk);
                cmp({tag, "_hold_req"}, 32'(chk_if.check_req), 32'd1);
                cmp({tag, "_hold_cx"}, 32'(chk_if.check_x), 32'(v.cx));
                cmp({tag, "_hold_cy"}, 32'(chk_if.check_y), 32'(v.cy));
            end
            chk_if.check_ack  = 1'b1;
            chk_if.check_free = v.free;
            @(negedge clk);
            chk_if.check_ack  = 1'b0;
            chk_if.check_free = 1'b0;
            cmp({tag, "_req_drop"}, 32'(chk_if.check_req), 32'd0);
        end
        pop_cmp(tag);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(negedge clk);
    endtask

    task automatic tick_once();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v [9];
        vec_t r;
        int exp_s;

        //        btn      dly free req  cx  cy   x   y  spr
        v[0] = '{4'b0000, 0, 1'b0, 1'b0,  0,  0, 32, 32, 0};
        v[1] = '{4'b0001, 3, 1'b1, 1'b1, 34, 32, 34, 32, 4};
        v[2] = '{4'b0010, 1, 1'b1, 1'b1, 32, 32, 32, 32, 3};
        v[3] = '{4'b0010, 0, 1'b1, 1'b0,  0,  0, 32, 32, 3};
        v[4] = '{4'b1010, 0, 1'b1, 1'b0,  0,  0, 32, 32, 1};
        v[5] = '{4'b0100, 2, 1'b0, 1'b1, 32, 34, 32, 32, 2};
        v[6] = '{4'b0100, 0, 1'b1, 1'b1, 32, 34, 32, 34, 2};
        v[7] = '{4'b1000, 2, 1'b1, 1'b1, 32, 32, 32, 32, 1};
        v[8] = '{4'b0001, 1, 1'b1, 1'b1, 34, 32, 34, 32, 4};

        chk_if.check_ack  = 1'b0;
        chk_if.check_free = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        cmp("rst_x", 32'(px), 32'd32);
        cmp("rst_y", 32'(py), 32'd32);
        cmp("rst_spr", 32'(spr), 32'd0);
        cmp("rst_alive", 32'(alive), 32'd1);
        cmp("rst_req", 32'(chk_if.check_req), 32'd0);
        cmp("rst_cx", 32'(chk_if.check_x), 32'd0);
        cmp("rst_cy", 32'(chk_if.check_y), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_frame(v[i], $sformatf("vec%0d", i));

        // Keep walking right: ten accepted right moves from X=32 end at X=52.
        for (int i = 0; i < 9; i++) begin
            r = '{4'b0001, 1, 1'b1, 1'b1, 36 + 2 * i, 32, 36 + 2 * i, 32, 4};
            run_frame(r, $sformatf("walk%0d", i));
        end
        cmp("walk_final_x", 32'(px), 32'd52);

        // Hit while the maze check is outstanding: handshake completes, no move.
        @(negedge clk);
        btn_down = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        cmp("hitchk_req", 32'(chk_if.check_req), 32'd1);
        cmp("hitchk_cy", 32'(chk_if.check_y), 32'd34);
        hit = 1'b1;
        btn_down = 1'b0;
        @(negedge clk);
        hit = 1'b0;
        cmp("hitchk_still_req", 32'(chk_if.check_req), 32'd1);
        chk_if.check_ack  = 1'b1;
        chk_if.check_free = 1'b1;
        push_exp(52, 32, 5, 0);
        @(negedge clk);
        chk_if.check_ack  = 1'b0;
        chk_if.check_free = 1'b0;
        cmp("hitchk_req_drop", 32'(chk_if.check_req), 32'd0);
        pop_cmp("hitchk");

        // Death timer: buttons and a stray hit are ignored while dead.
        btn_right = 1'b1;
        for (int t = 1; t <= 64; t++) begin
            if (t == 20) hit = 1'b1;
            tick_once();
            hit = 1'b0;
            if (t == 7 || t == 8 || t == 16 || t == 63) begin
                exp_s = ((t / 8) % 2 == 1) ? 6 : 5;
                cmp($sformatf("dead_t%0d_spr", t), 32'(spr), 32'(exp_s));
                cmp($sformatf("dead_t%0d_alive", t), 32'(alive), 32'd0);
                cmp($sformatf("dead_t%0d_req", t), 32'(chk_if.check_req), 32'd0);
            end
        end
        btn_right = 1'b0;
        cmp("respawn_alive", 32'(alive), 32'd1);
        cmp("respawn_spr", 32'(spr), 32'd0);
        cmp("respawn_x", 32'(px), 32'd32);
        cmp("respawn_y", 32'(py), 32'd32);

        // Hit and frame_tick together in IDLE: death wins; then reset mid-DEAD.
        r = '{4'b0001, 0, 1'b1, 1'b1, 34, 32, 34, 32, 4};
        run_frame(r, "pre_hit");
        @(negedge clk);
        hit = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        frame_tick = 1'b0;
        cmp("hittick_alive", 32'(alive), 32'd0);
        cmp("hittick_spr", 32'(spr), 32'd5);
        cmp("hittick_req", 32'(chk_if.check_req), 32'd0);
        tick_once();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("rstdead_alive", 32'(alive), 32'd1);
        cmp("rstdead_x", 32'(px), 32'd32);
        cmp("rstdead_spr", 32'(spr), 32'd0);

        // Reset while the maze check is pending; a late ack must be ignored.
        r = '{4'b0001, 0, 1'b1, 1'b1, 34, 32, 34, 32, 4};
        run_frame(r, "pre_rstchk");
        @(negedge clk);
        btn_right = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        btn_right = 1'b0;
        cmp("rstchk_req", 32'(chk_if.check_req), 32'd1);
        cmp("rstchk_cx", 32'(chk_if.check_x), 32'd36);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("rstchk_req_after", 32'(chk_if.check_req), 32'd0);
        cmp("rstchk_x", 32'(px), 32'd32);
        cmp("rstchk_alive", 32'(alive), 32'd1);
        chk_if.check_ack  = 1'b1;
        chk_if.check_free = 1'b1;
        @(negedge clk);
        chk_if.check_ack  = 1'b0;
        chk_if.check_free = 1'b0;
        @(negedge clk);
        cmp("lateack_x", 32'(px), 32'd32);
        cmp("lateack_spr", 32'(spr), 32'd0);
        cmp("lateack_req", 32'(chk_if.check_req), 32'd0);

        r = '{4'b0001, 2, 1'b1, 1'b1, 34, 32, 34, 32, 4};
        run_frame(r, "recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
